// File: rtl/msg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : msg_pkg                                                      |
// | Description : Shared types and message ROM for the scrolling message ctrl. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package msg_pkg;

    localparam int MSG_LEN   = 8;
    localparam int IDX_W     = $clog2(MSG_LEN);
    localparam int LETTER_W  = 3;
    localparam int DIGITS_W  = MSG_LEN * LETTER_W;

    typedef enum logic [LETTER_W-1:0] {
        LETTER_BLANK = 3'b000,
        LETTER_H     = 3'b001,
        LETTER_E     = 3'b010,
        LETTER_L     = 3'b011,
        LETTER_O     = 3'b100
    } letter_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10
    } state_t;

    // Index 0 is the first letter shifted in.
    localparam letter_t MSG_ROM [MSG_LEN] = '{
        LETTER_H, LETTER_E, LETTER_L, LETTER_L,
        LETTER_O, LETTER_BLANK, LETTER_BLANK, LETTER_BLANK
    };

endpackage : msg_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tick_gen                                                     |
// | Description : Divide-by-TICK_DIV counter; tick marks the terminal count.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] C_TERMINAL = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_terminal;

    assign w_at_terminal = (r_cnt == C_TERMINAL);
    // Tick only fires while counting, so a held counter never produces a shift.
    assign tick          = run && w_at_terminal;

    always_ff @(posedge Clock) begin
        if (Reset || clear) begin
            r_cnt <= '0;
        end else if (run) begin
            if (w_at_terminal) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule : tick_gen
`default_nettype wire

// File: rtl/msg_scroll_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : msg_scroll_ctrl                                              |
// | Description : Scrolls "HELLO" across eight letter digits with pause/step.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module msg_scroll_ctrl
    import msg_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Stop,
    input  logic                Pause,
    input  logic                Step,
    output logic [DIGITS_W-1:0] Digits,
    output logic                Busy,
    output logic                Wrap
);

    state_t              r_state;
    state_t              w_next_state;
    logic [DIGITS_W-1:0] r_digits;
    logic [IDX_W-1:0]    r_idx;
    logic                r_busy;
    logic                r_wrap;

    logic                w_shift;
    logic                w_load;
    logic                w_tick;
    logic                w_cnt_run;
    logic                w_cnt_clear;

    // Counter advances only in RUN on edges that neither stop nor pause.
    assign w_cnt_run   = (r_state == ST_RUN) && !Stop && !Pause;
    assign w_cnt_clear = (r_state == ST_IDLE) || Stop;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .Clock (Clock),
        .Reset (Reset),
        .run   (w_cnt_run),
        .clear (w_cnt_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_shift      = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start && !Stop) begin
                    w_next_state = ST_RUN;
                    w_load       = 1'b1;
                end
            end
            ST_RUN: begin
                if (Stop) begin
                    w_next_state = ST_IDLE;
                    w_load       = 1'b1;
                end else if (Pause) begin
                    w_next_state = ST_PAUSED;
                end else if (w_tick) begin
                    w_shift = 1'b1;
                end
            end
            ST_PAUSED: begin
                if (Stop) begin
                    w_next_state = ST_IDLE;
                    w_load       = 1'b1;
                end else if (!Pause) begin
                    w_next_state = ST_RUN;
                end else if (Step) begin
                    w_shift = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_load       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_digits <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_busy <= (w_next_state != ST_IDLE);
            r_wrap <= w_shift && (r_idx == IDX_W'(MSG_LEN - 1));
            if (w_load) begin
                r_digits <= '0;
                r_idx    <= '0;
            end else if (w_shift) begin
                r_digits <= {r_digits[DIGITS_W-LETTER_W-1:0], MSG_ROM[r_idx]};
                r_idx    <= r_idx + 1'b1;
            end
        end
    end

    assign Digits = r_digits;
    assign Busy   = r_busy;
    assign Wrap   = r_wrap;

endmodule : msg_scroll_ctrl
`default_nettype wire

// File: tb/tb_msg_scroll_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_msg_scroll_ctrl                                           |
// | Description : Directed self-checking bench for msg_scroll_ctrl, TICK_DIV=4.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_msg_scroll_ctrl;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Stop  = 1'b0;
    logic        Pause = 1'b0;
    logic        Step  = 1'b0;
    logic [23:0] Digits;
    logic        Busy;
    logic        Wrap;

    int n_checks = 0;
    int n_errors = 0;

    msg_scroll_ctrl #(
        .TICK_DIV (4)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Start  (Start),
        .Stop   (Stop),
        .Pause  (Pause),
        .Step   (Step),
        .Digits (Digits),
        .Busy   (Busy),
        .Wrap   (Wrap)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; outputs are sampled 1 time unit after the last edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    initial begin
        cyc(2);
        check("rst_digits", {8'h0, Digits}, 32'h0);
        check("rst_busy",   {31'h0, Busy},  32'h0);
        check("rst_wrap",   {31'h0, Wrap},  32'h0);

        Reset = 1'b0;
        Step  = 1'b1;
        cyc(1);
        Step = 1'b0;
        check("idle_step_ignored", {8'h0, Digits}, 32'h0);

        // Start sampled at edge 0
        Start = 1'b1;
        cyc(1);
        Start = 1'b0;
        check("busy_after_start", {31'h0, Busy}, 32'h1);
        check("blank_after_start", {8'h0, Digits}, 32'h0);
        cyc(3);
        check("no_shift_edge3", {8'h0, Digits}, 32'h0);
        cyc(1);
        check("shift_edge4", {8'h0, Digits}, 32'h000001);
        cyc(4);
        check("shift_edge8", {8'h0, Digits}, 32'h00000A);
        cyc(23);
        check("wrap_edge31", {31'h0, Wrap}, 32'h0);
        cyc(1);
        check("digits_edge32", {8'h0, Digits}, 32'h29B800);
        check("wrap_edge32",   {31'h0, Wrap},  32'h1);
        cyc(1);
        check("wrap_edge33",   {31'h0, Wrap},  32'h0);
        cyc(3);
        check("digits_edge36", {8'h0, Digits}, 32'h4DC001);

        // Pause sampled at edge 39, counter held at 2 (terminal would be edge 40)
        cyc(2);
        Pause = 1'b1;
        cyc(1);
        check("pause_busy", {31'h0, Busy}, 32'h1);
        cyc(20);
        check("pause_frozen", {8'h0, Digits}, 32'h4DC001);
        Pause = 1'b0;
        cyc(1);
        check("resume_edge", {8'h0, Digits}, 32'h4DC001);
        cyc(1);
        check("resume_plus1", {8'h0, Digits}, 32'h4DC001);
        cyc(1);
        check("resume_shift", {8'h0, Digits}, 32'h6E000A);

        // Step three times while paused
        Pause = 1'b1;
        cyc(1);
        Step = 1'b1; cyc(1); Step = 1'b0;
        check("step1", {8'h0, Digits}, 32'h700053);
        cyc(3);
        check("step1_hold", {8'h0, Digits}, 32'h700053);
        Step = 1'b1; cyc(1); Step = 1'b0;
        check("step2", {8'h0, Digits}, 32'h80029B);
        cyc(3);
        Step = 1'b1; cyc(1); Step = 1'b0;
        check("step3", {8'h0, Digits}, 32'h0014DC);
        cyc(5);
        check("step3_hold", {8'h0, Digits}, 32'h0014DC);
        check("step_wrap", {31'h0, Wrap}, 32'h0);

        // Stop and Start together while running
        Pause = 1'b0;
        cyc(1);
        Stop = 1'b1; Start = 1'b1;
        cyc(1);
        Stop = 1'b0; Start = 1'b0;
        check("stop_digits", {8'h0, Digits}, 32'h0);
        check("stop_busy",   {31'h0, Busy},  32'h0);
        cyc(6);
        check("stop_stays_idle", {31'h0, Busy}, 32'h0);

        // Start with Stop in idle stays idle
        Stop = 1'b1; Start = 1'b1;
        cyc(1);
        Stop = 1'b0; Start = 1'b0;
        check("idle_start_stop", {31'h0, Busy}, 32'h0);

        // Reset coinciding with a terminal count
        Start = 1'b1;
        cyc(1);
        Start = 1'b0;
        cyc(8);
        check("rerun_edge8", {8'h0, Digits}, 32'h00000A);
        cyc(3);
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
        check("midrst_digits", {8'h0, Digits}, 32'h0);
        check("midrst_busy",   {31'h0, Busy},  32'h0);
        check("midrst_wrap",   {31'h0, Wrap},  32'h0);
        cyc(5);
        check("post_rst_idle", {8'h0, Digits}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_msg_scroll_ctrl
`default_nettype wire

// File: doc/msg_scroll_ctrl.md
MSG_SCROLL_CTRL -- requirements
Module: msg_scroll_ctrl

Interface
REQ-001 Parameter: TICK_DIV, default 50_000_000, clock cycles per scroll shift; legal range 2 to 2^26.
REQ-002 Port: Clock  in  1  sole clock; all state updates on posedge.
REQ-003 Port: Reset  in  1  synchronous, active-high reset.
REQ-004 Port: Start  in  1  one-cycle request to begin scrolling from idle.
REQ-005 Port: Stop  in  1  one-cycle request to abort scrolling and blank the display.
REQ-006 Port: Pause  in  1  level; while high, timed shifting is frozen.
REQ-007 Port: Step  in  1  one-cycle request for a single manual shift while paused.
REQ-008 Port: Digits  out  24  eight 3-bit letter codes; digit 7 = [23:21] leftmost, digit 0 = [2:0] rightmost.
REQ-009 Port: Busy  out  1  high in RUN and PAUSED.
REQ-010 Port: Wrap  out  1  one-cycle pulse coinciding with the shift that consumes message index 7.

Function
REQ-011 Letter codes SHALL be: Blank 000, H 001, E 010, L 011, O 100; codes 101-111 are never driven.
REQ-012 Message ROM SHALL be, for index 0..7: H, E, L, L, O, Blank, Blank, Blank.
REQ-013 A shift SHALL be: Digits <= {Digits[20:0], msg[idx]}; idx <= (idx+1) mod 8; idx is a 3-bit register that wraps 7->0 naturally.
REQ-014 States SHALL be IDLE, RUN and PAUSED; all outputs are registered.
REQ-015 IDLE: Start -> RUN with idx=0, tick counter=0, Digits=all Blank; all other inputs ignored.
REQ-016 RUN: the tick counter counts 0..TICK_DIV-1; a shift occurs on the edge after the counter reaches TICK_DIV-1, and the counter returns to 0 on that edge.
REQ-017 First-shift latency SHALL be exact: Start sampled at edge N -> first Digits change at edge N+TICK_DIV; subsequent shifts occur every TICK_DIV edges.
REQ-018 RUN with Pause=1 -> PAUSED; the tick counter holds its value and no shift occurs on that edge, even if a terminal count coincides.
REQ-019 PAUSED with Pause=0 -> RUN; the counter resumes from its held value.
REQ-020 PAUSED with Step=1 and Pause=1 -> one shift on that edge; the state remains PAUSED and the counter is unchanged.
REQ-021 Step SHALL be ignored in IDLE and RUN; Start SHALL be ignored in RUN and PAUSED.
REQ-022 Stop in RUN or PAUSED -> IDLE with Digits=all Blank, idx=0, counter=0; Stop in IDLE has no effect.
REQ-023 Priority on the same edge SHALL be: Reset > Stop > Pause > Step/tick; Start together with Stop in IDLE -> remain IDLE.
REQ-024 Wrap SHALL be 1 only in the cycle following a shift of index 7, whether the shift was timed or stepped, and 0 otherwise.
REQ-025 Busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-026 Reset=1 at a posedge SHALL force IDLE, Digits=0x000000, idx=0, counter=0, Busy=0, Wrap=0, regardless of current state or in-flight shift.
REQ-027 No output SHALL change between clock edges because of Reset (no asynchronous path).

Structure
REQ-028 Package msg_pkg SHALL hold the letter_t enum (3-bit), the state_t enum, MSG_LEN=8, and the message ROM constant.
REQ-029 Sub-module tick_gen SHALL hold the TICK_DIV counter, with inputs run/clear and output tick; counter width = $clog2(TICK_DIV).
REQ-030 The FSM, index register, shift register and Wrap/Busy logic SHALL reside in msg_scroll_ctrl.

Verification (TICK_DIV=4)
REQ-031 Reset, then Start at edge 0 -> Digits=0x000001 after edge 4, 0x00000A after edge 8, Busy=1 from edge 1.
REQ-032 Continue running -> after edge 32, Digits=0x29B800 and Wrap=1 for exactly that cycle; after edge 36, Digits=0x4DC001.
REQ-033 Assert Pause one cycle before a terminal count -> Digits frozen for 20 cycles; release -> the next shift occurs after the remaining count, not a full period.
REQ-034 While paused, pulse Step three times -> exactly three shifts, one per pulse, with no timed shifts in between.
REQ-035 Stop and Start asserted on the same edge while running -> IDLE, Digits=0x000000, Busy=0 on the next cycle.
REQ-036 Reset asserted mid-run on the same edge as a terminal count -> no shift; all outputs 0 after that edge.
